// File: rtl/mips_dmem_responder.sv
// Data-memory responder for the single-cycle MIPS core: word RAM plus an MMIO page
// with a console TX byte FIFO, a HALT register, a store counter and a sticky error flag.
module mips_dmem_responder #(
    parameter int unsigned DEPTH     = 64,
    parameter int unsigned TXQ_DEPTH = 4,
    parameter logic [31:0] MMIO_BASE = 32'hFFFF_FF00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] dataadr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        halted,
    output logic [31:0] halt_code,
    output logic        err,
    output logic [31:0] store_count
);

    localparam int unsigned RAM_AW = $clog2(DEPTH);
    localparam int unsigned TXQ_AW = $clog2(TXQ_DEPTH);
    localparam int unsigned PTR_W  = TXQ_AW + 1;

    typedef enum logic [1:0] {
        REG_TXDATA = 2'd0,
        REG_STATUS = 2'd1,
        REG_HALT   = 2'd2,
        REG_COUNT  = 2'd3
    } mmio_reg_e;

    logic [31:0]       ram_q [DEPTH];
    logic [7:0]        fifo_q [TXQ_DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic              ovf_q, ovf_d;
    logic              err_q, err_d;
    logic              halted_q, halted_d;
    logic [31:0]       halt_code_q, halt_code_d;
    logic [31:0]       store_count_q, store_count_d;

    logic              is_mmio;
    mmio_reg_e         reg_sel;
    logic [29:0]       word_idx;
    logic              ram_hit;
    logic [RAM_AW-1:0] ram_idx;
    logic              aligned;

    logic [PTR_W-1:0]  fifo_count;
    logic              fifo_empty;
    logic              fifo_full;

    logic              accept;
    logic              reject;
    logic              push_req;
    logic              push_ok;
    logic              pop;
    logic              halt_wr;
    logic              ram_we;

    // Address decode: the MMIO page shadows whatever RAM index it would otherwise map to.
    assign is_mmio  = (dataadr[31:4] == MMIO_BASE[31:4]);
    assign reg_sel  = mmio_reg_e'(dataadr[3:2]);
    assign word_idx = dataadr[31:2];
    assign ram_hit  = !is_mmio && (word_idx < 30'(DEPTH));
    assign ram_idx  = word_idx[RAM_AW-1:0];
    assign aligned  = (dataadr[1:0] == 2'b00);

    assign fifo_count = wr_ptr_q - rd_ptr_q;
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[TXQ_AW] != rd_ptr_q[TXQ_AW]) &&
                        (wr_ptr_q[TXQ_AW-1:0] == rd_ptr_q[TXQ_AW-1:0]);

    assign pop     = !fifo_empty && tx_ready;
    assign push_ok = push_req && (!fifo_full || pop);

    always_comb begin
        accept   = 1'b0;
        reject   = 1'b0;
        push_req = 1'b0;
        halt_wr  = 1'b0;
        ram_we   = 1'b0;
        if (memwrite && !halted_q) begin
            if (!aligned) begin
                reject = 1'b1;
            end else if (is_mmio) begin
                case (reg_sel)
                    REG_TXDATA: begin
                        accept   = 1'b1;
                        push_req = 1'b1;
                    end
                    REG_HALT: begin
                        accept  = 1'b1;
                        halt_wr = 1'b1;
                    end
                    default: begin
                        reject = 1'b1;
                    end
                endcase
            end else if (ram_hit) begin
                accept = 1'b1;
                ram_we = 1'b1;
            end else begin
                reject = 1'b1;
            end
        end
    end

    // A push into a full FIFO still counts as an accepted store; only the byte is lost.
    always_comb begin
        wr_ptr_d      = wr_ptr_q + PTR_W'(push_ok);
        rd_ptr_d      = rd_ptr_q + PTR_W'(pop);
        ovf_d         = ovf_q || (push_req && fifo_full && !pop);
        err_d         = err_q || reject;
        halted_d      = halted_q || halt_wr;
        halt_code_d   = halt_wr ? writedata : halt_code_q;
        store_count_d = store_count_q + 32'(accept);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            ovf_q         <= 1'b0;
            err_q         <= 1'b0;
            halted_q      <= 1'b0;
            halt_code_q   <= '0;
            store_count_q <= '0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            ovf_q         <= ovf_d;
            err_q         <= err_d;
            halted_q      <= halted_d;
            halt_code_q   <= halt_code_d;
            store_count_q <= store_count_d;
        end
    end

    // Storage arrays carry no reset; reset only suppresses a concurrent write.
    always_ff @(posedge clk) begin
        if (!reset && ram_we) begin
            ram_q[ram_idx] <= writedata;
        end
        if (!reset && push_ok) begin
            fifo_q[wr_ptr_q[TXQ_AW-1:0]] <= writedata[7:0];
        end
    end

    always_comb begin
        readdata = '0;
        if (is_mmio) begin
            case (reg_sel)
                REG_TXDATA: readdata = 32'(fifo_count);
                REG_STATUS: readdata = {28'b0, ovf_q, err_q, fifo_full, fifo_empty};
                REG_HALT:   readdata = halt_code_q;
                default:    readdata = store_count_q;
            endcase
        end else if (ram_hit) begin
            readdata = ram_q[ram_idx];
        end
    end

    assign tx_valid    = !fifo_empty;
    assign tx_data     = fifo_empty ? 8'h00 : fifo_q[rd_ptr_q[TXQ_AW-1:0]];
    assign halted      = halted_q;
    assign halt_code   = halt_code_q;
    assign err         = err_q;
    assign store_count = store_count_q;

endmodule

// File: tb/tb_mips_dmem_responder.sv
// Self-checking bench for mips_dmem_responder: a directed vector table followed by
// randomized traffic compared against a queue/array based reference model.
module tb_mips_dmem_responder;

    localparam int unsigned DEPTH     = 64;
    localparam int unsigned TXQ_DEPTH = 4;
    localparam logic [31:0] MMIO_BASE = 32'hFFFF_FF00;
    localparam logic [31:0] M         = MMIO_BASE;

    logic        clk = 1'b0;
    logic        reset;
    logic        memwrite;
    logic [31:0] dataadr;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        halted;
    logic [31:0] halt_code;
    logic        err;
    logic [31:0] store_count;

    int compared   = 0;
    int mismatched = 0;

    mips_dmem_responder #(
        .DEPTH(DEPTH),
        .TXQ_DEPTH(TXQ_DEPTH),
        .MMIO_BASE(MMIO_BASE)
    ) dut (
        .clk(clk),
        .reset(reset),
        .memwrite(memwrite),
        .dataadr(dataadr),
        .writedata(writedata),
        .readdata(readdata),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .halted(halted),
        .halt_code(halt_code),
        .err(err),
        .store_count(store_count)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] m_ram [DEPTH];
    logic [7:0]  m_q [$];
    bit          m_ovf;
    bit          m_err;
    bit          m_halted;
    logic [31:0] m_code;
    logic [31:0] m_cnt;

    typedef struct {
        bit          rst;
        bit          we;
        logic [31:0] adr;
        logic [31:0] wd;
        bit          rdy;
        logic [31:0] exp_rd;
        logic [31:0] exp_cnt;
        bit          exp_err;
        bit          exp_valid;
        logic [7:0]  exp_txd;
        bit          exp_halt;
        logic [31:0] exp_code;
    } vec_t;

    vec_t vecs [$];

    function automatic void addVec(bit rst, bit we, logic [31:0] adr, logic [31:0] wd, bit rdy,
                                   logic [31:0] exp_rd, logic [31:0] exp_cnt, bit exp_err,
                                   bit exp_valid, logic [7:0] exp_txd, bit exp_halt,
                                   logic [31:0] exp_code);
        vec_t v;
        v.rst = rst; v.we = we; v.adr = adr; v.wd = wd; v.rdy = rdy;
        v.exp_rd = exp_rd; v.exp_cnt = exp_cnt; v.exp_err = exp_err;
        v.exp_valid = exp_valid; v.exp_txd = exp_txd; v.exp_halt = exp_halt;
        v.exp_code = exp_code;
        vecs.push_back(v);
    endfunction

    function automatic bit inMmio(logic [31:0] a);
        return (a >= MMIO_BASE) && ((a - MMIO_BASE) < 32'd16);
    endfunction

    function automatic logic [31:0] modelLoad(logic [31:0] a);
        int unsigned slot;
        if (inMmio(a)) begin
            slot = (a - MMIO_BASE) / 4;
            case (slot)
                0: return 32'(m_q.size());
                1: return {28'b0, m_ovf, m_err, m_q.size() == TXQ_DEPTH, m_q.size() == 0};
                2: return m_code;
                default: return m_cnt;
            endcase
        end
        if (a / 4 < DEPTH) return m_ram[a / 4];
        return 32'd0;
    endfunction

    task automatic modelClock(bit rst, bit we, logic [31:0] a, logic [31:0] d, bit rdy);
        int unsigned slot;
        if (rst) begin
            m_q.delete();
            m_ovf = 0; m_err = 0; m_halted = 0; m_code = 0; m_cnt = 0;
            return;
        end
        if (rdy && m_q.size() != 0) void'(m_q.pop_front());
        if (we && !m_halted) begin
            if (a % 4 != 0) begin
                m_err = 1;
            end else if (inMmio(a)) begin
                slot = (a - MMIO_BASE) / 4;
                if (slot == 0) begin
                    m_cnt++;
                    if (m_q.size() < TXQ_DEPTH) m_q.push_back(d[7:0]);
                    else m_ovf = 1;
                end else if (slot == 2) begin
                    m_cnt++;
                    m_code = d;
                    m_halted = 1;
                end else begin
                    m_err = 1;
                end
            end else if (a / 4 < DEPTH) begin
                m_ram[a / 4] = d;
                m_cnt++;
            end else begin
                m_err = 1;
            end
        end
    endtask

    task automatic applyStimulus(bit rst, bit we, logic [31:0] adr, logic [31:0] wd, bit rdy);
        @(negedge clk);
        reset     = rst;
        memwrite  = we;
        dataadr   = adr;
        writedata = wd;
        tx_ready  = rdy;
        @(posedge clk);
        modelClock(rst, we, adr, wd, rdy);
        #1;
    endtask

    task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic checkAgainstModel(int cyc);
        checkOutput($sformatf("rnd%0d readdata", cyc), readdata, modelLoad(dataadr));
        checkOutput($sformatf("rnd%0d tx_valid", cyc), 32'(tx_valid), 32'(m_q.size() != 0));
        if (m_q.size() != 0)
            checkOutput($sformatf("rnd%0d tx_data", cyc), 32'(tx_data), 32'(m_q[0]));
        checkOutput($sformatf("rnd%0d halted", cyc), 32'(halted), 32'(m_halted));
        checkOutput($sformatf("rnd%0d halt_code", cyc), halt_code, m_code);
        checkOutput($sformatf("rnd%0d err", cyc), 32'(err), 32'(m_err));
        checkOutput($sformatf("rnd%0d store_count", cyc), store_count, m_cnt);
    endtask

    initial begin
        logic [31:0] adr;
        int          kind;
        bit          rst;

        reset = 1'b1; memwrite = 1'b0; dataadr = '0; writedata = '0; tx_ready = 1'b0;
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("reset tx_valid", 32'(tx_valid), 32'd0);
        checkOutput("reset tx_data", 32'(tx_data), 32'd0);
        checkOutput("reset store_count", store_count, 32'd0);

        // Preload every RAM word so later loads have known contents.
        for (int i = 0; i < int'(DEPTH); i++)
            applyStimulus(0, 1, 32'(i * 4), 32'hA000_0000 + 32'(i), 0);
        applyStimulus(1, 0, 0, 0, 0);

        //     rst we adr      wd            rdy exp_rd        cnt err vld txd    hlt code
        addVec(0, 1, 84,     32'h9504,     0, 32'h9504,      1, 0, 0, 8'h00, 0, 0);
        addVec(0, 1, 88,     32'h0,        0, 32'h0,         2, 0, 0, 8'h00, 0, 0);
        addVec(0, 0, 84,     32'h0,        0, 32'h9504,      2, 0, 0, 8'h00, 0, 0);
        addVec(0, 0, 88,     32'h0,        0, 32'h0,         2, 0, 0, 8'h00, 0, 0);
        addVec(0, 1, 86,     32'hDEAD,     0, 32'h9504,      2, 1, 0, 8'h00, 0, 0);
        addVec(0, 1, 256,    32'h1234,     0, 32'h0,         2, 1, 0, 8'h00, 0, 0);
        addVec(0, 0, M + 4,  32'h0,        0, 32'h5,         2, 1, 0, 8'h00, 0, 0);
        addVec(0, 1, M,      32'h48,       0, 32'h1,         3, 1, 1, 8'h48, 0, 0);
        addVec(0, 1, M,      32'h69,       0, 32'h2,         4, 1, 1, 8'h48, 0, 0);
        addVec(0, 0, M,      32'h0,        0, 32'h2,         4, 1, 1, 8'h48, 0, 0);
        addVec(0, 0, M,      32'h0,        1, 32'h1,         4, 1, 1, 8'h69, 0, 0);
        addVec(0, 0, M,      32'h0,        1, 32'h0,         4, 1, 0, 8'h00, 0, 0);
        addVec(0, 1, M,      32'h31,       0, 32'h1,         5, 1, 1, 8'h31, 0, 0);
        addVec(0, 1, M,      32'h32,       0, 32'h2,         6, 1, 1, 8'h31, 0, 0);
        addVec(0, 1, M,      32'h33,       0, 32'h3,         7, 1, 1, 8'h31, 0, 0);
        addVec(0, 1, M,      32'h34,       0, 32'h4,         8, 1, 1, 8'h31, 0, 0);
        addVec(0, 1, M,      32'h35,       1, 32'h4,         9, 1, 1, 8'h32, 0, 0);
        addVec(0, 0, M + 4,  32'h0,        0, 32'h6,         9, 1, 1, 8'h32, 0, 0);
        addVec(0, 1, M,      32'h36,       0, 32'h4,        10, 1, 1, 8'h32, 0, 0);
        addVec(0, 0, M + 4,  32'h0,        0, 32'hE,        10, 1, 1, 8'h32, 0, 0);
        addVec(0, 0, M,      32'h0,        1, 32'h3,        10, 1, 1, 8'h33, 0, 0);
        addVec(0, 0, M,      32'h0,        1, 32'h2,        10, 1, 1, 8'h34, 0, 0);
        addVec(0, 0, M,      32'h0,        1, 32'h1,        10, 1, 1, 8'h35, 0, 0);
        addVec(0, 0, M,      32'h0,        1, 32'h0,        10, 1, 0, 8'h00, 0, 0);
        addVec(0, 1, M + 8,  32'h1,        0, 32'h1,        11, 1, 0, 8'h00, 1, 1);
        addVec(0, 1, 84,     32'hFFFF,     0, 32'h9504,     11, 1, 0, 8'h00, 1, 1);
        addVec(0, 1, M + 8,  32'h7,        0, 32'h1,        11, 1, 0, 8'h00, 1, 1);
        addVec(1, 0, 84,     32'h0,        0, 32'h9504,      0, 0, 0, 8'h00, 0, 0);
        addVec(0, 1, M,      32'h41,       0, 32'h1,         1, 0, 1, 8'h41, 0, 0);
        addVec(0, 1, M,      32'h42,       0, 32'h2,         2, 0, 1, 8'h41, 0, 0);
        addVec(0, 1, M,      32'h43,       0, 32'h3,         3, 0, 1, 8'h41, 0, 0);
        addVec(0, 1, M,      32'h44,       0, 32'h4,         4, 0, 1, 8'h41, 0, 0);
        addVec(0, 1, M + 8,  32'h2,        0, 32'h2,         5, 0, 1, 8'h41, 1, 2);
        addVec(0, 0, M,      32'h0,        1, 32'h3,         5, 0, 1, 8'h42, 1, 2);
        addVec(0, 1, M,      32'h45,       0, 32'h3,         5, 0, 1, 8'h42, 1, 2);
        addVec(1, 1, M,      32'h46,       1, 32'h0,         0, 0, 0, 8'h00, 0, 0);
        addVec(0, 0, 84,     32'h0,        0, 32'h9504,      0, 0, 0, 8'h00, 0, 0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].we, vecs[i].adr, vecs[i].wd, vecs[i].rdy);
            checkOutput($sformatf("row%0d readdata", i), readdata, vecs[i].exp_rd);
            checkOutput($sformatf("row%0d store_count", i), store_count, vecs[i].exp_cnt);
            checkOutput($sformatf("row%0d err", i), 32'(err), 32'(vecs[i].exp_err));
            checkOutput($sformatf("row%0d tx_valid", i), 32'(tx_valid), 32'(vecs[i].exp_valid));
            if (vecs[i].exp_valid)
                checkOutput($sformatf("row%0d tx_data", i), 32'(tx_data), 32'(vecs[i].exp_txd));
            checkOutput($sformatf("row%0d halted", i), 32'(halted), 32'(vecs[i].exp_halt));
            checkOutput($sformatf("row%0d halt_code", i), halt_code, vecs[i].exp_code);
        end
        checkOutput("post-reset tx_data", 32'(tx_data), 32'd0);

        // Randomized traffic with occasional resets, compared cycle by cycle with the model.
        for (int cyc = 0; cyc < 1500; cyc++) begin
            rst  = ($urandom_range(0, 99) < 2);
            kind = int'($urandom_range(0, 9));
            case (kind)
                0, 1, 2, 3: adr = 32'($urandom_range(0, DEPTH - 1)) * 4;
                4:          adr = 32'($urandom_range(0, DEPTH - 1)) * 4 + 32'($urandom_range(1, 3));
                5:          adr = 32'(DEPTH * 4) + 32'($urandom_range(0, 63)) * 4;
                6, 7:       adr = MMIO_BASE;
                8:          adr = MMIO_BASE + 32'($urandom_range(0, 15));
                default:    adr = $urandom;
            endcase
            applyStimulus(rst, 1'($urandom_range(0, 1)), adr, $urandom,
                          ($urandom_range(0, 2) == 0));
            checkAgainstModel(cyc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
